// File: rtl/single_port_ram_controller_if.sv
// Command, read-response, RAM-port and status signals of the single-port RAM controller.
interface single_port_ram_controller_if #(
  parameter int MEM_WIDTH  = 24,
  parameter int ADDR_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [MEM_WIDTH-1:0]  cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [MEM_WIDTH-1:0]  rsp_rdata;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [MEM_WIDTH-1:0]  ram_din;
  logic [MEM_WIDTH-1:0]  ram_dout;

  logic                  busy;

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, ram_dout,
    output cmd_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_din, busy
  );

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, ram_dout,
    input  cmd_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_din, busy
  );
endinterface

// File: rtl/single_port_ram_controller.sv
// Single-port RAM front end: read data lands in a response FIFO two cycles after acceptance.
// Commands are credit-gated on FIFO occupancy plus the in-flight read, so rsp_ready stalls never overflow.
module single_port_ram_controller #(
  parameter int MEM_WIDTH  = 24,
  parameter int ADDR_WIDTH = 8,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  single_port_ram_controller_if.slave   bus
);
  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [PW-1:0]  PTR_LAST = PW'(RSP_DEPTH - 1);
  localparam logic [CW-1:0]  COUNT_FULL = CW'(RSP_DEPTH);
  localparam logic [CW1-1:0] CREDITS = CW1'(RSP_DEPTH);

  logic                 pending_q, pending_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [MEM_WIDTH-1:0] buf_q [RSP_DEPTH];

  logic           accept;
  logic           push;
  logic           pop;
  logic           rsp_vld;
  logic [CW1-1:0] credit_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Credits count the read still in flight as well as buffered responses.
  assign credit_used   = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
  assign bus.cmd_ready = rst_n & (credit_used < CREDITS);

  assign accept       = bus.cmd_valid & bus.cmd_ready;
  assign bus.ram_we   = accept & bus.cmd_we;
  assign bus.ram_addr = bus.cmd_addr;
  assign bus.ram_din  = bus.cmd_wdata;

  assign rsp_vld       = (count_q != '0);
  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_rdata = buf_q[rd_ptr_q];
  assign bus.busy      = pending_q | rsp_vld;

  assign push = pending_q;
  assign pop  = rsp_vld & bus.rsp_ready;

  always_comb begin
    pending_d = accept & ~bus.cmd_we;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // Response storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= bus.ram_dout;
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == COUNT_FULL)));
`endif
endmodule

// File: tb/tb_single_port_ram_controller.sv
// Bench for single_port_ram_controller: directed scenarios with literal expectations plus a randomized run.
module tb_single_port_ram_controller;
  localparam int W     = 24;
  localparam int A     = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  single_port_ram_controller_if #(.MEM_WIDTH(W), .ADDR_WIDTH(A)) bus();

  single_port_ram_controller #(.MEM_WIDTH(W), .ADDR_WIDTH(A), .RSP_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first RAM with a registered output.
  logic [W-1:0] ram_arr [0:255];
  always @(posedge clk) begin
    if (bus.ram_we) begin
      ram_arr[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout          <= bus.ram_din;
    end else begin
      bus.ram_dout <= ram_arr[bus.ram_addr];
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: memory contents as of accepted commands, and outstanding reads with acceptance cycle.
  logic [W-1:0] ref_mem [0:255];
  logic [W-1:0] data_q [$];
  int           cyc_q  [$];

  always @(negedge clk) begin : model
    logic exp_rdy;
    logic exp_vld;
    cyc = cyc + 1;
    if (!rst_n) begin
      data_q.delete();
      cyc_q.delete();
      chk1("rst_cmd_ready", bus.cmd_ready, 1'b0);
      chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_ram_we", bus.ram_we, 1'b0);
    end else begin
      exp_rdy = (data_q.size() < DEPTH);
      exp_vld = (data_q.size() != 0) && (cyc_q[0] <= cyc - 2);
      chk1("cmd_ready", bus.cmd_ready, exp_rdy);
      chk1("rsp_valid", bus.rsp_valid, exp_vld);
      chk1("busy", bus.busy, data_q.size() != 0);
      chk1("ram_we", bus.ram_we, bus.cmd_valid & exp_rdy & bus.cmd_we);
      chkw("ram_addr", 32'(bus.ram_addr), 32'(bus.cmd_addr));
      chkw("ram_din", 32'(bus.ram_din), 32'(bus.cmd_wdata));
      if (exp_vld) begin
        chkw("rsp_rdata", 32'(bus.rsp_rdata), 32'(data_q[0]));
        if (bus.rsp_ready) begin
          void'(data_q.pop_front());
          void'(cyc_q.pop_front());
        end
      end
      if (bus.cmd_valid && exp_rdy) begin
        if (bus.cmd_we) begin
          ref_mem[bus.cmd_addr] = bus.cmd_wdata;
        end else begin
          data_q.push_back(ref_mem[bus.cmd_addr]);
          cyc_q.push_back(cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [A-1:0] addr, input logic [W-1:0] wd);
    bus.cmd_valid = v;
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
  endtask

  initial begin
    int   acc;
    int   got;
    logic acc_prev;
    logic last_rdy;

    rst_n         = 1'b0;
    bus.rsp_ready = 1'b1;
    drive(1'b1, 1'b1, 8'h33, 24'h111111);
    repeat (3) @(negedge clk);

    tick();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 24'h0);
    @(negedge clk);
    chk1("post_reset_ready", bus.cmd_ready, 1'b1);

    // Write 0xA5A5A5 to 0x10 then read it back.
    tick(); drive(1'b1, 1'b1, 8'h10, 24'hA5A5A5);
    @(negedge clk); chk1("wr10_ram_we", bus.ram_we, 1'b1);
    tick(); drive(1'b1, 1'b0, 8'h10, 24'h000000);
    @(negedge clk); chk1("rd10_ram_we", bus.ram_we, 1'b0);
    tick(); drive(1'b0, 1'b0, 8'h00, 24'h0);
    @(negedge clk); chk1("rd10_t1_valid", bus.rsp_valid, 1'b0); chk1("rd10_t1_busy", bus.busy, 1'b1);
    tick();
    @(negedge clk); chk1("rd10_t2_valid", bus.rsp_valid, 1'b1); chkw("rd10_t2_data", 32'(bus.rsp_rdata), 32'h00A5A5A5);
    tick();
    @(negedge clk); chk1("rd10_t3_valid", bus.rsp_valid, 1'b0); chk1("rd10_t3_busy", bus.busy, 1'b0);

    // Preload 0..3 with 1..4, then back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      tick(); drive(1'b1, 1'b1, A'(i), W'(i + 1));
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i < 4) drive(1'b1, 1'b0, A'(i), 24'h0);
      else       drive(1'b0, 1'b0, 8'h00, 24'h0);
      @(negedge clk);
      if (i < 4) chk1("b2b_cmd_ready", bus.cmd_ready, 1'b1);
      if (i >= 2) begin
        chk1("b2b_rsp_valid", bus.rsp_valid, 1'b1);
        chkw("b2b_rsp_data", 32'(bus.rsp_rdata), 32'(i - 1));
      end
    end

    // Stalled consumer: exactly DEPTH reads fit, then drain in order.
    tick(); bus.rsp_ready = 1'b0; drive(1'b0, 1'b0, 8'h00, 24'h0);
    acc = 0;
    last_rdy = 1'b1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      tick(); drive(1'b1, 1'b0, A'(acc % 4), 24'h0);
      @(negedge clk);
      last_rdy = bus.cmd_ready;
      if (bus.cmd_ready) acc++;
    end
    chkw("full_accepts", 32'(acc), 32'(DEPTH));
    chk1("full_cmd_ready", last_rdy, 1'b0);
    got = 0;
    for (int n = 0; n < 20 && got < DEPTH; n++) begin
      tick();
      if (n == 0) begin
        drive(1'b0, 1'b0, 8'h00, 24'h0);
        bus.rsp_ready = 1'b1;
      end
      @(negedge clk);
      if (bus.rsp_valid) begin
        chkw("drain_data", 32'(bus.rsp_rdata), 32'((got % 4) + 1));
        got++;
      end
    end
    chkw("drain_count", 32'(got), 32'(DEPTH));
    tick();
    @(negedge clk); chk1("drain_cmd_ready", bus.cmd_ready, 1'b1);

    // A lone write produces no response.
    tick(); drive(1'b1, 1'b1, 8'h20, 24'h123456);
    @(negedge clk); chk1("wr20_ram_we", bus.ram_we, 1'b1); chk1("wr20_busy", bus.busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); drive(1'b0, 1'b0, 8'h00, 24'h0);
      @(negedge clk);
      chk1("wr20_after_we", bus.ram_we, 1'b0);
      chk1("wr20_after_valid", bus.rsp_valid, 1'b0);
      chk1("wr20_after_busy", bus.busy, 1'b0);
    end

    // Reset right after a read is accepted discards it.
    tick(); drive(1'b1, 1'b0, 8'h20, 24'h0);
    @(negedge clk);
    tick(); rst_n = 1'b0; drive(1'b0, 1'b0, 8'h00, 24'h0);
    @(negedge clk); chk1("inrst_busy", bus.busy, 1'b0);
    tick(); rst_n = 1'b1;
    @(negedge clk); chk1("rel_cmd_ready", bus.cmd_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk1("rel_rsp_valid", bus.rsp_valid, 1'b0);
      chk1("rel_busy", bus.busy, 1'b0);
      tick();
      @(negedge clk);
    end

    // Randomized traffic over a small address window.
    for (int i = 0; i < 16; i++) begin
      tick(); drive(1'b1, 1'b1, A'(8'h40 + i), W'($urandom));
    end
    acc_prev = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (!bus.cmd_valid || acc_prev)
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              A'(8'h40 + $urandom_range(0, 15)), W'($urandom));
      bus.rsp_ready = (n % 200 < 30) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc_prev = bus.cmd_valid && bus.cmd_ready;
    end
    tick(); drive(1'b0, 1'b0, 8'h00, 24'h0); bus.rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk1("final_busy", bus.busy, 1'b0);
    chkw("final_outstanding", 32'(data_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/single_port_ram_controller.md
SINGLE_PORT_RAM_CONTROLLER -- requirements
Module: single_port_ram_controller

Interface
REQ-001 Parameter MEM_WIDTH, default 24, data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 8, RAM address width in bits.
REQ-003 Parameter RSP_DEPTH, default 4, read-response buffer entries; minimum 3.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  in  1  command present.
REQ-007 cmd_ready  out  1  command can be accepted.
REQ-008 cmd_we  in  1  1 = write command, 0 = read command.
REQ-009 cmd_addr  in  ADDR_WIDTH  command address.
REQ-010 cmd_wdata  in  MEM_WIDTH  write data, ignored for reads.
REQ-011 rsp_valid  out  1  read data available.
REQ-012 rsp_ready  in  1  consumer takes read data.
REQ-013 rsp_rdata  out  MEM_WIDTH  read data, valid when rsp_valid = 1.
REQ-014 ram_we  out  1  RAM write enable.
REQ-015 ram_addr  out  ADDR_WIDTH  RAM address.
REQ-016 ram_din  out  MEM_WIDTH  RAM write data.
REQ-017 ram_dout  in  MEM_WIDTH  RAM registered output, 1-cycle read latency, write-first.
REQ-018 busy  out  1  read in flight or response buffered.

Function
REQ-019 Command accepted in a cycle when cmd_valid = 1 and cmd_ready = 1; payload is held by the producer until accepted.
REQ-020 The RAM ports are combinational from the command: ram_addr = cmd_addr, ram_din = cmd_wdata, ram_we = cmd_valid & cmd_ready & cmd_we.
REQ-021 Read acceptance at edge T sets the pending register to 1 for cycle T+1. Otherwise pending is 0 at the next edge.
REQ-022 When pending = 1, ram_dout is pushed into the response FIFO at the end of that cycle. Write cycles never push, so write-first ram_dout is discarded.
REQ-023 Read latency: a read accepted in cycle T gives rsp_valid = 1 with its data no earlier than cycle T+2. That is exactly T+2 when the FIFO is empty.
REQ-024 Responses leave in command order. The FIFO pops on rsp_valid & rsp_ready. A push and a pop in the same cycle leave the count unchanged.
REQ-025 rsp_valid = (count != 0). rsp_rdata = head entry, held stable while rsp_valid = 1 and rsp_ready = 0.
REQ-026 cmd_ready = rst_n & ((count + pending) < RSP_DEPTH), from registered state only, with no combinational path from cmd_* or rsp_ready. This applies to writes as well.
REQ-027 Credit rule guarantees the FIFO never overflows. A push with count = RSP_DEPTH is a design error; it is flagged by an assertion in simulation.
REQ-028 Sustained throughput is one command per cycle while rsp_ready stays 1.
REQ-029 busy = pending | (count != 0).
REQ-030 Count is $clog2(RSP_DEPTH+1) bits wide. FIFO pointers wrap modulo RSP_DEPTH.

Reset
REQ-031 rst_n low asynchronously clears pending, count and the FIFO pointers.
REQ-032 While rst_n is low: rsp_valid = 0, busy = 0, cmd_ready = 0, ram_we = 0.
REQ-033 Reset during an in-flight read discards that read. No response appears after reset release.
REQ-034 FIFO data storage is not reset.
REQ-035 cmd_ready = 1 in the first cycle after rst_n rises.

Verification
REQ-036 Write 0xA5A5A5 to addr 0x10, then read 0x10, with rsp_ready = 1 -> rsp_valid rises 2 cycles after read acceptance with rsp_rdata = 0xA5A5A5.
REQ-037 Back-to-back reads of addr 0,1,2,3 preloaded with 1,2,3,4, rsp_ready = 1 -> cmd_ready stays 1 and responses 1,2,3,4 appear on consecutive cycles.
REQ-038 rsp_ready = 0 with continuous reads -> exactly RSP_DEPTH reads accepted, then cmd_ready = 0. Raising rsp_ready drains the data in order and cmd_ready returns to 1.
REQ-039 Write of 0x123456 to addr 0x20 -> ram_we = 1 for one cycle, busy remains 0, no rsp_valid.
REQ-040 Read accepted, then rst_n pulsed low in the next cycle -> rsp_valid never asserts and busy = 0 after release.
REQ-041 Random mix of commands with random rsp_ready against a behavioural write-first RAM model -> all read data matches the model in order, with no overflow assertion.
